// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and helpers for the ARM fetch stage.
package pipeline_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'hE1A0_0000;  // mov r0,r0
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          PC_INCR      = 4;

    // Saturating 32-bit increment used by the fetch performance counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] val);
        return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_decode_reg.sv
// F->D pipeline register: flush beats stall, stall holds, otherwise capture the fetched instruction.
module fetch_decode_reg
    import pipeline_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic [31:0]      InstrF,
    input  logic [WIDTH-1:0] PCPlus8F,
    output logic [31:0]      InstrD,
    output logic [WIDTH-1:0] PCPlus8D,
    output logic             ValidD
);

    logic [31:0]      instr_d, instr_q;
    logic [WIDTH-1:0] pc_plus8_d, pc_plus8_q;
    logic             valid_d, valid_q;

    always_comb begin
        instr_d    = instr_q;
        pc_plus8_d = pc_plus8_q;
        valid_d    = valid_q;
        if (reset || FlushD) begin
            instr_d    = NOP_INSTR;
            pc_plus8_d = '0;
            valid_d    = 1'b0;
        end else if (!StallD) begin
            instr_d    = InstrF;
            pc_plus8_d = PCPlus8F;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        instr_q    <= instr_d;
        pc_plus8_q <= pc_plus8_d;
        valid_q    <= valid_d;
    end

    assign InstrD   = instr_q;
    assign PCPlus8D = pc_plus8_q;
    assign ValidD   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// ARM fetch stage: PC register, next-PC select and F->D register.
// Optional StallCntF/FlushCntD performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             BranchTakenE,
    input  logic [WIDTH-1:0] ALUResultE,
    input  logic             PCSrcW,
    input  logic [WIDTH-1:0] ResultW,
    output logic [WIDTH-1:0] PCF,
    input  logic [31:0]      InstrF,
    output logic [31:0]      InstrD,
    output logic [WIDTH-1:0] PCPlus8D,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]      StallCntF,
    output logic [31:0]      FlushCntD,
`endif
    output logic             ValidD
);

    logic [WIDTH-1:0] pc_d, pc_q;
    logic [WIDTH-1:0] pc_plus4_f, pc_plus8_f;

    assign pc_plus4_f = pc_q + WIDTH'(PC_INCR);
    assign pc_plus8_f = pc_plus4_f + WIDTH'(PC_INCR);

    // Writeback redirect outranks execute redirect; either one overrides StallF.
    always_comb begin
        pc_d = pc_q;
        if (reset)             pc_d = RESET_PC;
        else if (PCSrcW)       pc_d = ResultW;
        else if (BranchTakenE) pc_d = ALUResultE;
        else if (!StallF)      pc_d = pc_plus4_f;
    end

    always_ff @(posedge clk) begin
        pc_q <= pc_d;
    end

    assign PCF = pc_q;

    fetch_decode_reg #(.WIDTH(WIDTH)) u_fd_reg (
        .clk      (clk),
        .reset    (reset),
        .StallD   (StallD),
        .FlushD   (FlushD),
        .InstrF   (InstrF),
        .PCPlus8F (pc_plus8_f),
        .InstrD   (InstrD),
        .PCPlus8D (PCPlus8D),
        .ValidD   (ValidD)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_d, stall_cnt_q;
    logic [31:0] flush_cnt_d, flush_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (reset) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (StallF) stall_cnt_d = sat_inc32(stall_cnt_q);
            if (FlushD) flush_cnt_d = sat_inc32(flush_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        stall_cnt_q <= stall_cnt_d;
        flush_cnt_q <= flush_cnt_d;
    end

    assign StallCntF = stall_cnt_q;
    assign FlushCntD = flush_cnt_q;
`endif

endmodule
